// File: rtl/perf_mon_pkg.sv
// Shared types and limits for the pipeline performance-event monitor.
package perf_mon_pkg;

   localparam int unsigned N_EVT_MAX     = 16;
   localparam int unsigned CNT_W_MIN     = 8;
   localparam int unsigned CNT_W_MAX     = 32;
   // The cycle counter occupies the readout slot directly after the event channels.
   localparam int unsigned CYCLE_SEL_OFS = 0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } mon_state_e;

   function automatic int unsigned cycle_sel(input int unsigned n_evt);
      return n_evt + CYCLE_SEL_OFS;
   endfunction

endpackage

// File: rtl/perf_counter.sv
// Single event counter with sticky overflow flag.
// Wraps to zero by default; saturates when PERF_SATURATE_EN is defined.
module perf_counter
   import perf_mon_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);

   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             w_at_max;

   assign w_at_max = &r_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (clr_i) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (inc_i) begin
         if (w_at_max) begin
`ifdef PERF_SATURATE_EN
            r_cnt <= r_cnt;
`else
            r_cnt <= '0;
`endif
            r_ovf <= 1'b1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign cnt_o = r_cnt;
   assign ovf_o = r_ovf;

endmodule

// File: rtl/perf_event_monitor.sv
// Windowed cycle/hazard-event monitor with registered readout mux.
// Overflow mode selected by PERF_SATURATE_EN (saturate) vs. default (wrap).
module perf_event_monitor
   import perf_mon_pkg::*;
#(
   parameter int unsigned N_EVT       = 4,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned CYCLE_LIMIT = 30,
   parameter int unsigned SEL_W       = $clog2(N_EVT + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             clear_i,
   input  logic [N_EVT-1:0] event_i,
   input  logic [SEL_W-1:0] rd_sel_i,
   output logic [CNT_W-1:0] rd_data_o,
   output logic [CNT_W-1:0] cycle_o,
   output logic [N_EVT:0]   ovf_o,
   output logic             running_o,
   output logic             done_o
);

   localparam int unsigned      CYCLE_SEL = cycle_sel(N_EVT);
   localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(CYCLE_LIMIT - 1);

   if (N_EVT < 1 || N_EVT > N_EVT_MAX) begin : g_bad_n_evt
      $error("perf_event_monitor: N_EVT out of range");
   end
   if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
      $error("perf_event_monitor: CNT_W out of range");
   end
   if ((64'(CYCLE_LIMIT) >> CNT_W) != 64'd0) begin : g_bad_limit
      $error("perf_event_monitor: CYCLE_LIMIT does not fit in CNT_W");
   end

   mon_state_e       r_state;
   mon_state_e       w_state_next;
   logic             w_count_en;
   logic             w_limit_hit;
   logic [N_EVT:0]   w_inc;
   logic [N_EVT:0]   w_ovf;
   logic [CNT_W-1:0] w_cnt [N_EVT+1];
   logic [CNT_W-1:0] w_rd_next;
   logic [CNT_W-1:0] r_rd_data;

   // Every edge spent in RUN is counted, including the one that enters DONE.
   assign w_count_en  = (r_state == StRun) && !clear_i;
   assign w_limit_hit = (CYCLE_LIMIT != 0) && (w_cnt[CYCLE_SEL] == LIMIT_M1);
   assign w_inc       = {w_count_en, event_i & {N_EVT{w_count_en}}};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (clear_i) begin
         w_state_next = StIdle;
      end else begin
         unique case (r_state)
            StIdle: if (start_i) w_state_next = StRun;
            StRun: begin
               if (w_limit_hit) begin
                  w_state_next = StDone;
               end else if (!start_i) begin
                  w_state_next = StIdle;
               end
            end
            StDone:  w_state_next = StDone;
            default: w_state_next = StIdle;
         endcase
      end
   end

   for (genvar g = 0; g <= N_EVT; g++) begin : g_cnt
      perf_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .clr_i (clear_i),
         .inc_i (w_inc[g]),
         .cnt_o (w_cnt[g]),
         .ovf_o (w_ovf[g])
      );
   end

   always_comb begin
      w_rd_next = '0;
      for (int unsigned i = 0; i <= N_EVT; i++) begin
         if (rd_sel_i == SEL_W'(i)) begin
            w_rd_next = w_cnt[i];
         end
      end
   end

   // Captures the pre-increment value seen at this edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_next;
      end
   end

   assign rd_data_o = r_rd_data;
   assign cycle_o   = w_cnt[CYCLE_SEL];
   assign ovf_o     = w_ovf;
   assign running_o = (r_state == StRun);
   assign done_o    = (r_state == StDone);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Self-checking bench: default instance (A) and an 8-bit unlimited instance (B).
module tb_perf_event_monitor;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        start_a = 1'b0, clr_a = 1'b0;
   logic [3:0]  ev_a    = '0;
   logic [2:0]  sel_a   = '0;
   logic [31:0] rd_a, cyc_a;
   logic [4:0]  ovf_a;
   logic        run_a, done_a;

   logic        start_b = 1'b0, clr_b = 1'b0;
   logic [3:0]  ev_b    = '0;
   logic [2:0]  sel_b   = '0;
   logic [7:0]  rd_b, cyc_b;
   logic [4:0]  ovf_b;
   logic        run_b, done_b;

   perf_event_monitor u_dut_a (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .start_i   (start_a),
      .clear_i   (clr_a),
      .event_i   (ev_a),
      .rd_sel_i  (sel_a),
      .rd_data_o (rd_a),
      .cycle_o   (cyc_a),
      .ovf_o     (ovf_a),
      .running_o (run_a),
      .done_o    (done_a)
   );

   perf_event_monitor #(
      .N_EVT       (4),
      .CNT_W       (8),
      .CYCLE_LIMIT (0)
   ) u_dut_b (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .start_i   (start_b),
      .clear_i   (clr_b),
      .event_i   (ev_b),
      .rd_sel_i  (sel_b),
      .rd_data_o (rd_b),
      .cycle_o   (cyc_b),
      .ovf_o     (ovf_b),
      .running_o (run_b),
      .done_o    (done_b)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // Model: true (unbounded) event totals per channel; index 4 is the cycle channel.
   longint      tc   [2][5];
   int          mode [2];   // 0 idle, 1 run, 2 done
   logic [31:0] rdx  [2];

   function automatic logic [31:0] expv(input longint t, input int w);
      longint m;
      m = (longint'(1) << w) - 1;
`ifdef PERF_SATURATE_EN
      return (t > m) ? 32'(m) : 32'(t);
`else
      return 32'(t % (m + 1));
`endif
   endfunction

   function automatic logic [31:0] ovfx(input int d, input int w);
      logic [31:0] v;
      longint      m;
      v = '0;
      m = (longint'(1) << w) - 1;
      for (int i = 0; i < 5; i++) v[i] = (tc[d][i] > m);
      return v;
   endfunction

   task automatic mdl_reset(input int d);
      for (int i = 0; i < 5; i++) tc[d][i] = 0;
      mode[d] = 0;
      rdx[d]  = '0;
   endtask

   task automatic mdl(input int d, input logic st, input logic cl, input logic [3:0] ev,
                      input logic [2:0] sl);
      int w;
      int lim;
      w   = (d == 0) ? 32 : 8;
      lim = (d == 0) ? 30 : 0;
      rdx[d] = (sl <= 3'd4) ? expv(tc[d][sl], w) : 32'd0;
      if (cl) begin
         for (int i = 0; i < 5; i++) tc[d][i] = 0;
         mode[d] = 0;
      end else begin
         case (mode[d])
            0: if (st) mode[d] = 1;
            1: begin
               tc[d][4]++;
               for (int i = 0; i < 4; i++) if (ev[i]) tc[d][i]++;
               if (lim != 0 && tc[d][4] == longint'(lim)) mode[d] = 2;
               else if (!st) mode[d] = 0;
            end
            default: ;
         endcase
      end
   endtask

   initial begin
      mdl_reset(0);
      mdl_reset(1);
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            mdl_reset(0);
            mdl_reset(1);
         end else begin
            mdl(0, start_a, clr_a, ev_a, sel_a);
            mdl(1, start_b, clr_b, ev_b, sel_b);
         end
         #1;
         chk("a.cycle", cyc_a, expv(tc[0][4], 32));
         chk("a.ovf", 32'(ovf_a), ovfx(0, 32));
         chk("a.running", 32'(run_a), 32'(mode[0] == 1));
         chk("a.done", 32'(done_a), 32'(mode[0] == 2));
         chk("a.rd_data", rd_a, rdx[0]);
         chk("b.cycle", 32'(cyc_b), expv(tc[1][4], 8));
         chk("b.ovf", 32'(ovf_b), ovfx(1, 8));
         chk("b.running", 32'(run_b), 32'(mode[1] == 1));
         chk("b.done", 32'(done_b), 32'(mode[1] == 2));
         chk("b.rd_data", 32'(rd_b), rdx[1]);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic run_a_tests();
      int done_at;
      logic [31:0] sweep [7];
      // Window with sparse events: 30 counted cycles, then frozen.
      start_a = 1'b1;
      for (int c = 0; c <= 40; c++) begin
         ev_a[0] = (c >= 2 && c <= 5);
         ev_a[1] = (c == 7);
         step();
      end
      ev_a = '0;
      chk("a.lit_cycle30", cyc_a, 32'd30);
      chk("a.lit_done", 32'(done_a), 32'd1);
      chk("a.lit_not_running", 32'(run_a), 32'd0);
      sel_a = 3'd0;
      step();
      chk("a.lit_cnt0", rd_a, 32'd4);
      sel_a = 3'd1;
      step();
      chk("a.lit_cnt1", rd_a, 32'd1);
      // Clear together with start while in DONE.
      clr_a = 1'b1;
      step();
      chk("a.lit_clr_cycle", cyc_a, 32'd0);
      chk("a.lit_clr_ovf", 32'(ovf_a), 32'd0);
      chk("a.lit_clr_idle", 32'(run_a), 32'd0);
      chk("a.lit_clr_notdone", 32'(done_a), 32'd0);
      clr_a = 1'b0;
      step();
      chk("a.lit_clr_then_run", 32'(run_a), 32'd1);
      start_a = 1'b0;
      step();
      clr_a = 1'b1;
      step();
      clr_a = 1'b0;
      // Window paused by dropping start for cycles 10..14.
      done_at = -1;
      for (int c = 0; c <= 45; c++) begin
         start_a = !(c >= 10 && c <= 14);
         ev_a    = 4'b0001;
         step();
         if (done_a && done_at < 0) done_at = c;
      end
      ev_a = '0;
      chk("a.lit_done_edge", 32'(done_at), 32'd35);
      chk("a.lit_pause_cycle", cyc_a, 32'd30);
      sweep = '{32'd30, 32'd0, 32'd0, 32'd0, 32'd30, 32'd0, 32'd0};
      for (int s = 0; s <= 6; s++) begin
         sel_a = 3'(s);
         step();
         chk("a.lit_sweep", rd_a, sweep[s]);
      end
   endtask

   task automatic run_b_tests();
      sel_b   = 3'd2;
      start_b = 1'b1;
      step();
      ev_b = 4'b0100;
      repeat (255) step();
      chk("b.lit_no_ovf_at_255", 32'(ovf_b[2]), 32'd0);
      step();
      chk("b.lit_ovf_at_256", 32'(ovf_b[2]), 32'd1);
      repeat (44) step();
      ev_b = '0;
      step();
`ifdef PERF_SATURATE_EN
      chk("b.lit_cnt2_300", 32'(rd_b), 32'd255);
`else
      chk("b.lit_cnt2_300", 32'(rd_b), 32'd44);
`endif
      chk("b.lit_ovf2_sticky", 32'(ovf_b[2]), 32'd1);
      start_b = 1'b0;
      step();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("a.lit_rst_cycle", cyc_a, 32'd0);
      chk("a.lit_rst_rd", rd_a, 32'd0);
      chk("a.lit_rst_ovf", 32'(ovf_a), 32'd0);
      chk("a.lit_rst_running", 32'(run_a), 32'd0);
      chk("a.lit_rst_done", 32'(done_a), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      fork
         run_a_tests();
         run_b_tests();
      join

      // Asynchronous reset between edges while running.
      clr_a = 1'b1;
      clr_b = 1'b1;
      step();
      clr_a   = 1'b0;
      clr_b   = 1'b0;
      start_a = 1'b1;
      start_b = 1'b1;
      ev_a    = 4'b1111;
      repeat (6) step();
      #2 rst_n = 1'b0;
      #1;
      chk("a.lit_async_cycle", cyc_a, 32'd0);
      chk("a.lit_async_rd", rd_a, 32'd0);
      chk("a.lit_async_ovf", 32'(ovf_a), 32'd0);
      chk("a.lit_async_running", 32'(run_a), 32'd0);
      chk("b.lit_async_cycle", 32'(cyc_b), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      chk("a.lit_restart_run", 32'(run_a), 32'd1);
      chk("a.lit_restart_cycle0", cyc_a, 32'd0);
      step();
      chk("a.lit_restart_cycle1", cyc_a, 32'd1);
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/perf_event_monitor.md
# perf_event_monitor

Synthesizable, parametrised pipeline event monitor for the pipelined CPU. It counts run cycles and up to N_EVT single-bit hazard events (stall, flush, branch and similar) over a bounded measurement window, then freezes. The bench and on-chip debug logic read the counts through a registered select/readout port. It sits beside the CPU core, shares clk_i, and takes its event strobes from the hazard-detection and IF/ID flush logic.

## Interface
- N_EVT, 4: number of event channels (1..16)
- CNT_W, 32: width of every counter, cycle counter included (8..32)
- CYCLE_LIMIT, 30: run cycles before automatic freeze; 0 means unlimited
- SEL_W, $clog2(N_EVT+1): readout select width, derived; not overridden
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  level; monitor counts while high
- clear_i  in  1  synchronous clear of all counters and flags
- event_i  in  N_EVT  per-channel event strobe, sampled each cycle
- rd_sel_i  in  SEL_W  readout select
- rd_data_o  out  CNT_W  registered readout
- cycle_o  out  CNT_W  live cycle counter
- ovf_o  out  N_EVT+1  sticky overflow flags; bit N_EVT is the cycle counter
- running_o  out  1  high in RUN
- done_o  out  1  high in DONE

## Operation
- The FSM has three states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE to RUN when start_i=1.
- RUN to IDLE when start_i=0. Counts are retained, so the window pauses and resumes.
- RUN to DONE on the edge where cycle_o becomes CYCLE_LIMIT (CYCLE_LIMIT≠0).
- DONE stays in DONE regardless of start_i. It leaves only on clear_i or reset.
- clear_i has priority over all other inputs in every state. It zeroes all counters and ovf_o, and the next state is IDLE. With clear_i and start_i both high, clear wins and RUN begins on the following edge if start_i is still high.
- In RUN, each edge:
  - cycle_o increments by 1.
  - Each event counter i increments by 1 when event_i[i]=1.
  - This includes the final edge that enters DONE, so exactly CYCLE_LIMIT cycles are counted.
- In IDLE and DONE, event_i is ignored.
- Counter arithmetic is unsigned, CNT_W bits. Overflow behaviour is set by the macro in Configuration. ovf_o[i] sets on the increment that would exceed 2^CNT_W−1.
- Readout:
  - rd_sel_i < N_EVT selects event counter rd_sel_i.
  - rd_sel_i = N_EVT selects the cycle counter.
  - Any larger value reads 0.

## Timing
- Reset values: rd_data_o=0, cycle_o=0, ovf_o=0, running_o=0, done_o=0, all counters 0.
- Counters update on the same edge that samples event_i. The new value is visible one cycle after the event cycle.
- rd_data_o latency is 1 cycle from rd_sel_i. It reflects the counter value as of that same edge, before that edge's increment.
- running_o and done_o are registered state decodes. running_o goes high on the edge after start_i rises.
- Asynchronous reset mid-run clears everything immediately, with no need to wait for a clock. The first edge after release with start_i=1 enters RUN.

## Configuration
- PERF_SATURATE_EN defined: counters saturate at 2^CNT_W−1 and hold; ovf_o sets on the first blocked increment.
- PERF_SATURATE_EN undefined: counters wrap to 0; ovf_o sets on wrap.
- In both cases ovf_o is sticky until clear_i or reset.

## Structure
- Package perf_mon_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the readout-select localparam for the cycle channel
  - the limits N_EVT_MAX=16, CNT_W_MIN=8
- Sub-module perf_counter: one CNT_W counter with inc, clear, wrap/saturate and an overflow flag. It is instantiated N_EVT+1 times from a generate loop.
- The top level holds the FSM, the readout mux register and the parameter checks. An elaboration error is raised if N_EVT or CNT_W is out of range.

## Test plan
- Default parameters; start_i=1 from cycle 0; event_i[0] high on cycles 2–5, event_i[1] high on cycle 7 -> after 30 cycles: done_o=1, cycle_o=30, counter0=4, counter1=1; counts frozen for a further 10 cycles.
- start_i dropped for cycles 10–14, then re-asserted; event_i[0] held high throughout -> done asserts 5 cycles later than otherwise; counter0=30, cycle_o=30.
- clear_i pulsed together with start_i in DONE -> all counters 0, ovf_o=0, state IDLE for 1 cycle, then RUN.
- CNT_W=8, CYCLE_LIMIT=0, event_i[2] held high for 300 cycles:
  - With PERF_SATURATE_EN: counter2=255 and ovf_o[2]=1 from cycle 256.
  - Without it: counter2=300 mod 256=44, and ovf_o[2]=1 after the wrap.
- Readout sweep of rd_sel_i over 0..N_EVT+2 -> correct value one cycle later; rd_sel_i=N_EVT returns cycle_o; rd_sel_i>N_EVT returns 0.
- rst_i asserted low asynchronously mid-run, between clock edges -> all outputs 0 before the next edge; restart counts from 0.
